rom_file_pac: RTL and testbench
===============================

// Module: rom_file_pac
// PURPOSE
//  Read-only maze map of every tile Pac-Man may occupy: 25 rows x 32 columns.
//  One 32-bit word per row; bit c = 1 means column c is walkable, 0 means wall.
//  Read by the Pac-Man movement logic to validate a next-tile move before committing it.
//  Synchronous-read ROM with contents fixed at synthesis; no write port.
// PARAMETERS
//  ADDR_WIDTH  5   row-address width (32 addressable rows)
//  DATA_WIDTH  32  columns per row; bit 0 = leftmost column, bit 31 = rightmost
//  NUM_ROWS    25  populated rows 0..24; rows NUM_ROWS..31 read as all-wall
// PORTS
//  clk     in   1   system clock; all state changes on rising edge
//  rst_n   in   1   reset, asynchronous, active-low
//  r_addr  in   5   row to read (0 = top row)
//  r_data  out  32  walkable mask of the addressed row, registered
// BEHAVIOUR
//  - One clock domain (clk). Reset is asynchronous and active-low (rst_n).
//  - rst_n low: r_data forced to 32'h0000_0000 immediately, held while low.
//  - Read latency is 1 cycle. At each rising clk with rst_n high:
//    r_data <= ROM[r_addr]. r_data is stable between edges.
//  - No enable and no handshake. A new address is accepted every cycle.
//  - r_addr is sampled only at the clock edge. Changes between edges have no effect.
//  - r_addr 25..31 (out of range): r_data <= 32'h0. No error flag.
//  - First edge after rst_n deasserts returns ROM[r_addr]. No warm-up cycle.
//  - ROM contents, hex, MSB = column 31:
//     row 0, 24                   : 0000_0000  (outer wall)
//     rows 1,5,9,15,19,23         : 7FFF_FFFE  (full corridor, cols 1..30)
//     rows 2-4, 20-22             : 4201_8042  (cols 1,6,15,16,25,30)
//     rows 6-8, 16-18             : 4210_0842  (cols 1,6,11,20,25,30)
//     rows 10,11,13,14            : 4200_0042  (cols 1,6,25,30)
//     row 12                      : FFFF_FFFF  (tunnel row; cols 0 and 31 open for wrap)
//  - Map invariants: vertically symmetric (ROM[r] == ROM[24-r]).
//    Horizontally mirror-symmetric (bit c == bit 31-c).
//    Columns 0 and 31 are walls in every row except row 12.
//  - Implement as a case/constant table indexed by r_addr. No inferred RAM initialisation files.
// TESTING
//  - Reset: hold rst_n=0 with r_addr=1 across edges -> r_data=0000_0000.
//    Release rst_n -> next edge r_data=7FFF_FFFE.
//  - Sweep r_addr=0..24, one per cycle -> r_data one edge later matches the table:
//    e.g. addr 0 -> 0000_0000, 2 -> 4201_8042, 6 -> 4210_0842, 10 -> 4200_0042, 12 -> FFFF_FFFF.
//  - Out of range: r_addr=25,28,31 -> r_data=0000_0000.
//  - Latency: change r_addr 12 -> 0 mid-cycle -> r_data stays FFFF_FFFF until the next rising edge, then 0000_0000.
//  - Async reset mid-stream: with r_data=FFFF_FFFF, drop rst_n between edges -> r_data=0 without waiting for clk.
//  - Symmetry check: for r=0..24, the value read at r equals the value read at 24-r,
//    and each word equals its own bit-reverse.

Source files
------------

// File: rtl/rom_file_pac.sv
// ---------------------------------------------------------------------------
// rom_file_pac
//   Read-only maze map used by the Pac-Man movement logic to validate a
//   next-tile move. 25 rows x 32 columns, one word per row; bit c set means
//   column c is walkable, clear means wall. Bit 0 is the leftmost column.
//   Rows NUM_ROWS..31 are not part of the maze and read as solid wall.
//   Read is synchronous with one cycle of latency and no enable.
//
// Ports
//   clk     in   1           system clock, rising-edge active
//   rst_n   in   1           asynchronous active-low reset (clears r_data)
//   r_addr  in   ADDR_WIDTH  row to read, 0 = top row
//   r_data  out  DATA_WIDTH  registered walkable mask of the addressed row
// ---------------------------------------------------------------------------
module rom_file_pac #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROWS   = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    // Row patterns. Every pattern is left/right mirror-symmetric, and the
    // row assignment below is top/bottom symmetric about row 12.
    localparam logic [31:0] ROW_WALL     = 32'h0000_0000;
    localparam logic [31:0] ROW_CORRIDOR = 32'h7FFF_FFFE;
    localparam logic [31:0] ROW_PILLAR_A = 32'h4201_8042;
    localparam logic [31:0] ROW_PILLAR_B = 32'h4210_0842;
    localparam logic [31:0] ROW_SIDES    = 32'h4200_0042;
    localparam logic [31:0] ROW_TUNNEL   = 32'hFFFF_FFFF;

    // Constant table lookup; anything outside the populated rows is wall.
    function automatic logic [DATA_WIDTH-1:0] rom_lookup(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] word;
        int          row;
        row  = int'(a);
        word = ROW_WALL;
        if (row < NUM_ROWS) begin
            case (row)
                0, 24:                  word = ROW_WALL;
                1, 5, 9, 15, 19, 23:    word = ROW_CORRIDOR;
                2, 3, 4, 20, 21, 22:    word = ROW_PILLAR_A;
                6, 7, 8, 16, 17, 18:    word = ROW_PILLAR_B;
                10, 11, 13, 14:         word = ROW_SIDES;
                12:                     word = ROW_TUNNEL;
                default:                word = ROW_WALL;
            endcase
        end
        return DATA_WIDTH'(word);
    endfunction

    logic [DATA_WIDTH-1:0] rom_word_p0;

    always_comb begin
        rom_word_p0 = rom_lookup(r_addr);
    end

    // Stage p0 -> output register: address sampled only at the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= rom_word_p0;
        end
    end

endmodule

// File: tb/tb_rom_file_pac.sv
// ---------------------------------------------------------------------------
// tb_rom_file_pac
//   Scoreboard bench for rom_file_pac. Stimulus pushes {address, expected
//   word} into a queue when it issues a read; an independent monitor pops
//   and compares one cycle later. Reset and mid-cycle behaviour is checked
//   directly at chosen instants.
// ---------------------------------------------------------------------------
module tb_rom_file_pac;

    logic        clk;
    logic        rst_n;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    rom_file_pac #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .NUM_ROWS   (25)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } txn_t;

    txn_t        sb_q[$];
    logic [31:0] exp_tab [0:31];
    logic [31:0] obs_tab [0:31];
    logic        issue;
    int          checks;
    int          errors;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Issue one read at the current (post-edge) instant; result due one edge later.
    task automatic drive(input logic [4:0] a);
        txn_t t;
        r_addr = a;
        issue  = 1'b1;
        t.addr = a;
        t.exp  = exp_tab[a];
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        issue = 1'b0;
    endtask

    // Hand-written map, row by row.
    initial begin
        for (int i = 0; i < 32; i++) begin
            exp_tab[i] = 32'h0000_0000;
            obs_tab[i] = 32'hDEAD_BEEF;
        end
        exp_tab[0]  = 32'h0000_0000;
        exp_tab[1]  = 32'h7FFF_FFFE;
        exp_tab[2]  = 32'h4201_8042;
        exp_tab[3]  = 32'h4201_8042;
        exp_tab[4]  = 32'h4201_8042;
        exp_tab[5]  = 32'h7FFF_FFFE;
        exp_tab[6]  = 32'h4210_0842;
        exp_tab[7]  = 32'h4210_0842;
        exp_tab[8]  = 32'h4210_0842;
        exp_tab[9]  = 32'h7FFF_FFFE;
        exp_tab[10] = 32'h4200_0042;
        exp_tab[11] = 32'h4200_0042;
        exp_tab[12] = 32'hFFFF_FFFF;
        exp_tab[13] = 32'h4200_0042;
        exp_tab[14] = 32'h4200_0042;
        exp_tab[15] = 32'h7FFF_FFFE;
        exp_tab[16] = 32'h4210_0842;
        exp_tab[17] = 32'h4210_0842;
        exp_tab[18] = 32'h4210_0842;
        exp_tab[19] = 32'h7FFF_FFFE;
        exp_tab[20] = 32'h4201_8042;
        exp_tab[21] = 32'h4201_8042;
        exp_tab[22] = 32'h4201_8042;
        exp_tab[23] = 32'h7FFF_FFFE;
        exp_tab[24] = 32'h0000_0000;
    end

    // Monitor: a read issued before edge k is compared at the falling edge after k.
    initial begin : monitor
        logic pend;
        txn_t t;
        forever begin
            @(posedge clk);
            pend = issue;
            @(negedge clk);
            if (pend) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got empty queue expected one entry");
                end else begin
                    t = sb_q.pop_front();
                    obs_tab[t.addr] = r_data;
                    check($sformatf("read_addr_%0d", t.addr), r_data, t.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        checks = 0;
        errors = 0;
        issue  = 1'b0;
        rst_n  = 1'b0;
        r_addr = 5'd1;

        // Reset held across several edges with a valid address applied.
        #1;
        check("reset_immediate", r_data, 32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", r_data, 32'h0000_0000);

        // First edge after release returns the addressed row.
        rst_n = 1'b1;
        drive(5'd1);

        // Full sweep of populated rows.
        for (int a = 0; a < 25; a++) drive(5'(a));

        // Out-of-range rows.
        drive(5'd25);
        drive(5'd28);
        drive(5'd31);

        // Back-to-back mix after out-of-range.
        drive(5'd12);
        drive(5'd0);
        drive(5'd12);

        // Address change between edges must not disturb the output.
        r_addr = 5'd12;
        @(posedge clk);
        #1;
        check("latency_pre", r_data, 32'hFFFF_FFFF);
        #3;
        r_addr = 5'd0;
        #1;
        check("latency_midcycle_hold", r_data, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("latency_after_edge", r_data, 32'h0000_0000);

        // Asynchronous reset between edges.
        r_addr = 5'd12;
        @(posedge clk);
        #1;
        check("async_pre", r_data, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", r_data, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("async_reset_held", r_data, 32'h0000_0000);
        rst_n = 1'b1;
        drive(5'd12);

        // Drain scoreboard.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        // Map symmetry over the values read during the sweep.
        for (int r = 0; r < 25; r++) begin
            check($sformatf("vsym_row_%0d", r), obs_tab[r], obs_tab[24-r]);
            check($sformatf("hsym_row_%0d", r), bitrev(obs_tab[r]), obs_tab[r]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
